anchor_scheduler: RTL

- Top-level sequencer for the edge-detector filter pipeline. Issues the single-cycle anchor_moving strobe that the per-stage filter controllers (gaussian, sobel, nms, hysteresis) sample to advance one window position.
- Tracks the anchor column/row across the frame and holds each move until the input window is loaded and every stage reports its final flag.
- Drains the pipeline with flush moves after the last anchor, then signals frame completion.

---
 rtl/anchor_scheduler.sv | 133 +++++++++++++
 1 files changed

// File: rtl/anchor_scheduler.sv
// Frame sequencer for the edge-detector filter pipeline: issues the anchor
// move strobe, tracks anchor col/row, drains with flush moves, flags done.
// Ports: clk, rst (async high), start, window_ready, stage_final[NUM_STAGES]
//   in; anchor_moving, flush, col_idx, row_idx, busy, frame_done out.
module anchor_scheduler #(
  parameter int NUM_STAGES  = 4,
  parameter int NUM_COLS    = 40,
  parameter int NUM_ROWS    = 480,
  parameter int FLUSH_MOVES = 3,
  localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1,
  localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  window_ready,
  input  logic [NUM_STAGES-1:0] stage_final,
  output logic                  anchor_moving,
  output logic                  flush,
  output logic [CW-1:0]         col_idx,
  output logic [RW-1:0]         row_idx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int FW = (FLUSH_MOVES > 0) ? $clog2(FLUSH_MOVES + 1) : 1;
  localparam logic [FW-1:0] FM = FW'(FLUSH_MOVES);
  localparam logic [CW-1:0] CL = CW'(NUM_COLS - 1);
  localparam logic [RW-1:0] RL = RW'(NUM_ROWS - 1);

  typedef enum logic [3:0] {
    IDLE, WAIT_READY, MOVE, SETTLE, WAIT_STAGES,
    FLUSH_MOVE, FLUSH_SETTLE, FLUSH_WAIT, DONE
  } state_t;

  state_t state, next;

  logic [CW-1:0] col_cnt, col_nxt;
  logic [RW-1:0] row_cnt, row_nxt;
  logic [FW-1:0] fl_cnt;
  logic          go;
  logic          last;
  logic          adv;
  logic          clr;

  assign go   = &stage_final;
  assign last = (col_cnt == CL) && (row_cnt == RL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    adv  = 1'b0;
    clr  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next = WAIT_READY;
          clr  = 1'b1;
        end
      end
      WAIT_READY: begin
        if (window_ready && go) next = MOVE;
      end
      MOVE:   next = SETTLE;
      // stages drop their flags a cycle after the strobe
      SETTLE: next = WAIT_STAGES;
      WAIT_STAGES: begin
        if (go) begin
          if (last) begin
            if (FLUSH_MOVES == 0) next = DONE;
            else                  next = FLUSH_MOVE;
          end else begin
            adv  = 1'b1;
            next = window_ready ? MOVE : WAIT_READY;
          end
        end
      end
      FLUSH_MOVE:   next = FLUSH_SETTLE;
      FLUSH_SETTLE: next = FLUSH_WAIT;
      FLUSH_WAIT: begin
        if (go) next = (fl_cnt < FM) ? FLUSH_MOVE : DONE;
      end
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  // next anchor position; fed to col_idx/row_idx on entry to MOVE
  always_comb begin
    col_nxt = col_cnt;
    row_nxt = row_cnt;
    if (clr) begin
      col_nxt = '0;
      row_nxt = '0;
    end else if (adv) begin
      if (col_cnt == CL) begin
        col_nxt = '0;
        row_nxt = row_cnt + 1'b1;
      end else begin
        col_nxt = col_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
      fl_cnt  <= '0;
      col_idx <= '0;
      row_idx <= '0;
    end else begin
      col_cnt <= col_nxt;
      row_cnt <= row_nxt;
      if (clr)                     fl_cnt <= '0;
      else if (state == FLUSH_MOVE) fl_cnt <= fl_cnt + 1'b1;
      if (next == MOVE) begin
        col_idx <= col_nxt;
        row_idx <= row_nxt;
      end
    end
  end

  assign anchor_moving = (state == MOVE) || (state == FLUSH_MOVE);
  assign flush         = (state == FLUSH_MOVE);
  assign busy          = (state != IDLE);
  assign frame_done    = (state == DONE);

endmodule
